// File: rtl/dmi_pkg.sv
// Shared DMI types and widths for the simulation DMI responder.
package dmi_pkg;

    localparam int unsigned DMI_ADDR_W = 7;
    localparam int unsigned DMI_DATA_W = 32;
    localparam int unsigned DMI_DEPTH  = 1 << DMI_ADDR_W;

    // Request opcode as carried on debug_req_bits_op.
    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RSVD  = 2'd3
    } dmi_op_e;

    // Response code; BUSY exists in the protocol but is never produced here.
    typedef enum logic [1:0] {
        SUCCESS = 2'd0,
        FAILED  = 2'd2,
        BUSY    = 2'd3
    } dmi_resp_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } dmi_state_e;

endpackage

// File: rtl/dmi_regfile.sv
// 128x32 register file: synchronous clear, one write port, one combinational read port.
module dmi_regfile
    import dmi_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [DMI_ADDR_W-1:0] waddr,
    input  logic [DMI_DATA_W-1:0] wdata,
    input  logic [DMI_ADDR_W-1:0] raddr,
    output logic [DMI_DATA_W-1:0] rdata
);

    logic [DMI_DATA_W-1:0] mem [DMI_DEPTH];

    // Storage: whole array cleared on reset, otherwise single-port write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DMI_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read so the top can capture the value at the accept edge.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/sim_dmi_responder.sv
// Simulation DMI responder: accepts one debug request, services it against a
// 128x32 register file and returns the response after RESP_LATENCY cycles.
// Optional feature macro DMI_ACCESS_COUNT_EN: adds an accepted-request counter
// readable at address 7'h7F (writes to 7'h7F are then ignored).
// RESP_LATENCY must be in 1..15 (4-bit wait counter).
module sim_dmi_responder
    import dmi_pkg::*;
#(
    parameter int unsigned           RESP_LATENCY  = 2,
    parameter logic [DMI_ADDR_W-1:0] DMSTATUS_ADDR = 7'h11,
    parameter logic [DMI_DATA_W-1:0] DMSTATUS_VAL  = 32'h0000_0C82
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  debug_req_valid,
    output logic                  debug_req_ready,
    input  logic [DMI_ADDR_W-1:0] debug_req_bits_addr,
    input  logic [1:0]            debug_req_bits_op,
    input  logic [DMI_DATA_W-1:0] debug_req_bits_data,
    output logic                  debug_resp_valid,
    input  logic                  debug_resp_ready,
    output logic [1:0]            debug_resp_bits_resp,
    output logic [DMI_DATA_W-1:0] debug_resp_bits_data
);

    localparam logic [3:0] WAIT_LOAD = 4'(RESP_LATENCY - 1);

    dmi_state_e            state;
    logic [3:0]            wait_cnt;
    dmi_op_e               req_op;
    logic                  accept;
    logic                  ro_addr;
    logic                  rf_we;
    logic [DMI_DATA_W-1:0] rf_rdata;
    logic [DMI_DATA_W-1:0] rd_value;
    dmi_resp_e             acc_resp;
    logic [DMI_DATA_W-1:0] acc_data;

`ifdef DMI_ACCESS_COUNT_EN
    localparam logic [DMI_ADDR_W-1:0] COUNT_ADDR = 7'h7F;
    logic [DMI_DATA_W-1:0] access_count;

    // Counts every accepted request regardless of op; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            access_count <= '0;
        end else if (accept) begin
            access_count <= access_count + 32'd1;
        end
    end
`endif

    // Accept decode and read-only address masking for the regfile write.
    always_comb begin
        req_op  = dmi_op_e'(debug_req_bits_op);
        accept  = (state == StIdle) && debug_req_valid;
        ro_addr = (debug_req_bits_addr == DMSTATUS_ADDR);
`ifdef DMI_ACCESS_COUNT_EN
        ro_addr = ro_addr || (debug_req_bits_addr == COUNT_ADDR);
`endif
        rf_we   = accept && (req_op == WRITE) && !ro_addr;
    end

    // Read-data mux: special addresses override the regfile value.
    always_comb begin
        rd_value = rf_rdata;
        if (debug_req_bits_addr == DMSTATUS_ADDR) begin
            rd_value = DMSTATUS_VAL;
        end
`ifdef DMI_ACCESS_COUNT_EN
        if (debug_req_bits_addr == COUNT_ADDR) begin
            rd_value = access_count;
        end
`endif
    end

    // Response contents are fixed at accept time.
    always_comb begin
        acc_resp = SUCCESS;
        acc_data = '0;
        case (req_op)
            READ:    acc_data = rd_value;
            RSVD:    acc_resp = FAILED;
            default: acc_data = '0;
        endcase
    end

    dmi_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (rf_we),
        .waddr (debug_req_bits_addr),
        .wdata (debug_req_bits_data),
        .raddr (debug_req_bits_addr),
        .rdata (rf_rdata)
    );

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= StIdle;
            wait_cnt             <= '0;
            debug_req_ready      <= 1'b1;
            debug_resp_valid     <= 1'b0;
            debug_resp_bits_resp <= '0;
            debug_resp_bits_data <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        debug_req_ready      <= 1'b0;
                        debug_resp_bits_resp <= acc_resp;
                        debug_resp_bits_data <= acc_data;
                        if (RESP_LATENCY == 1) begin
                            state            <= StResp;
                            debug_resp_valid <= 1'b1;
                        end else begin
                            state    <= StWait;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                StWait: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state            <= StResp;
                        debug_resp_valid <= 1'b1;
                    end
                end
                StResp: begin
                    if (debug_resp_ready) begin
                        state                <= StIdle;
                        debug_resp_valid     <= 1'b0;
                        debug_req_ready      <= 1'b1;
                        debug_resp_bits_resp <= '0;
                        debug_resp_bits_data <= '0;
                    end
                end
                default: begin
                    state           <= StIdle;
                    debug_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_dmi_responder.sv
// Self-checking bench for sim_dmi_responder: vector table plus hand sequences
// for back-pressure and mid-transaction reset. Honors DMI_ACCESS_COUNT_EN.
module tb_sim_dmi_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_code;
    logic [31:0] resp_data;

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  er;
        logic [31:0] ed;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   total = 0;
    int   bad   = 0;

    sim_dmi_responder #(
        .RESP_LATENCY (LAT)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .debug_req_valid      (req_valid),
        .debug_req_ready      (req_ready),
        .debug_req_bits_addr  (req_addr),
        .debug_req_bits_op    (req_op),
        .debug_req_bits_data  (req_data),
        .debug_resp_valid     (resp_valid),
        .debug_resp_ready     (resp_ready),
        .debug_resp_bits_resp (resp_code),
        .debug_resp_bits_data (resp_data)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endfunction

    // Wait for IDLE, present one request, hold it through the accept edge.
    task automatic issue(input logic [1:0] op, input logic [6:0] addr,
                         input logic [31:0] data, input logic [1:0] er,
                         input logic [31:0] ed, input bit push);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        if (push) begin
            e.resp = er;
            e.data = ed;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for the response, check latency and pop the scoreboard.
    task automatic collect();
        int n;
        exp_t e;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (resp_valid || n > 40) break;
        end
        check("resp_latency", 32'(n), 32'(LAT));
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("resp_code", 32'(resp_code), 32'(e.resp));
            check("resp_data", resp_data, e.data);
        end
        if (resp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic txn(input logic [1:0] op, input logic [6:0] addr,
                       input logic [31:0] data, input logic [1:0] er,
                       input logic [31:0] ed);
        issue(op, addr, data, er, ed, 1'b1);
        collect();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{2'd2, 7'h10, 32'hDEAD_BEEF, 2'd0, 32'h0};
        vecs[1]  = '{2'd1, 7'h10, 32'h0,         2'd0, 32'hDEAD_BEEF};
        vecs[2]  = '{2'd2, 7'h11, 32'hFFFF_FFFF, 2'd0, 32'h0};
        vecs[3]  = '{2'd1, 7'h11, 32'h0,         2'd0, 32'h0000_0C82};
        vecs[4]  = '{2'd2, 7'h05, 32'h0000_1234, 2'd0, 32'h0};
        vecs[5]  = '{2'd3, 7'h05, 32'hFFFF_0000, 2'd2, 32'h0};
        vecs[6]  = '{2'd1, 7'h05, 32'h0,         2'd0, 32'h0000_1234};
        vecs[7]  = '{2'd0, 7'h05, 32'h0000_0077, 2'd0, 32'h0};
        vecs[8]  = '{2'd2, 7'h00, 32'hA5A5_5A5A, 2'd0, 32'h0};
        vecs[9]  = '{2'd1, 7'h00, 32'h0,         2'd0, 32'hA5A5_5A5A};
        vecs[10] = '{2'd1, 7'h7E, 32'h0,         2'd0, 32'h0};
        vecs[11] = '{2'd3, 7'h11, 32'h0,         2'd2, 32'h0};
        vecs[12] = '{2'd2, 7'h7E, 32'h0000_0001, 2'd0, 32'h0};
        vecs[13] = '{2'd1, 7'h7E, 32'h0,         2'd0, 32'h0000_0001};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'd0;
        req_addr   = 7'h0;
        req_data   = 32'h0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_code", 32'(resp_code), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        reset = 1'b0;

        // Table-driven main function.
        for (int i = 0; i < 14; i++) begin
            txn(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].er, vecs[i].ed);
        end

        // Back-pressure: response held, new requests ignored.
        resp_ready = 1'b0;
        txn(2'd1, 7'h10, 32'h0, 2'd0, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_resp_valid", 32'(resp_valid), 32'd1);
            check("hold_resp_code", 32'(resp_code), 32'd0);
            check("hold_resp_data", resp_data, 32'hDEAD_BEEF);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            req_valid = 1'b1;
            req_op    = 2'd2;
            req_addr  = 7'h10;
            req_data  = 32'h0;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("release_resp_valid", 32'(resp_valid), 32'd0);
        check("release_req_ready", 32'(req_ready), 32'd1);
        txn(2'd1, 7'h10, 32'h0, 2'd0, 32'hDEAD_BEEF);

        // Reset during WAIT drops the transaction and clears the write.
        issue(2'd2, 7'h20, 32'h0000_0055, 2'd0, 32'h0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_resp_valid", 32'(resp_valid), 32'd0);
            check("midrst_req_ready", 32'(req_ready), 32'd1);
        end
        txn(2'd1, 7'h20, 32'h0, 2'd0, 32'h0);
        txn(2'd1, 7'h10, 32'h0, 2'd0, 32'h0);

        // Address 7'h7F behaviour depends on the build option.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
`ifdef DMI_ACCESS_COUNT_EN
        for (int i = 0; i < 3; i++) begin
            txn(2'd0, 7'h00, 32'h0, 2'd0, 32'h0);
        end
        txn(2'd1, 7'h7F, 32'h0, 2'd0, 32'd3);
        txn(2'd2, 7'h7F, 32'h0000_00A5, 2'd0, 32'h0);
        txn(2'd1, 7'h7F, 32'h0, 2'd0, 32'd5);
`else
        txn(2'd2, 7'h7F, 32'h0000_00A5, 2'd0, 32'h0);
        txn(2'd1, 7'h7F, 32'h0, 2'd0, 32'h0000_00A5);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
